// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   - FSM state encodings (RUN / MDU_WAIT / LSU_WAIT)
//   - default LSU watchdog limit
//   - packed bundles for the register enables and valid_fromCD bits
package ysyx_041461_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ysyx_041461_PCTRL_RUN      = 2'd0,
    ysyx_041461_PCTRL_MDU_WAIT = 2'd1,
    ysyx_041461_PCTRL_LSU_WAIT = 2'd2
  } pctrl_state_e;

  localparam int ysyx_041461_PCTRL_LSU_TIMEOUT = 1024;

  // Enables for PC and the four pipeline registers.
  typedef struct packed {
    logic pc;
    logic id;
    logic exe;
    logic mem;
    logic wb;
  } pctrl_en_t;

  // valid_fromCD for the four pipeline registers (0 = bubble).
  typedef struct packed {
    logic id;
    logic exe;
    logic mem;
    logic wb;
  } pctrl_vld_t;

endpackage

// File: rtl/ysyx_041461_pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EXE. x0 is never a hazard.
//   in : id_valid, id_rs1/2, id_use_rs1/2, exe_valid, exe_rd, exe_is_load
//   out: load_use
module ysyx_041461_hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       exe_valid,
  input  logic [4:0] exe_rd,
  input  logic       exe_is_load,
  output logic       load_use
);

  logic hit1, hit2;

  assign hit1     = id_use_rs1 && (id_rs1 == exe_rd);
  assign hit2     = id_use_rs2 && (id_rs2 == exe_rd);
  assign load_use = exe_valid && exe_is_load && (exe_rd != 5'd0) && id_valid && (hit1 || hit2);

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Drives PC / IF-ID / ID-EXE /
// EXE-MEM / MEM-WB enables and valid_fromCD, sequences MDU and LSU handshakes,
// and flushes on WB redirects. Registered FSM state; everything else is
// combinational from state and inputs.
//   in : clk, rst (async, active-high), ID/EXE/MEM/WB status, mdu_done, lsu_ack
//   out: pc_enable, *reg_enable, *reg_valid_fromCD, mdu_start, mdu_kill,
//        lsu_req, lsu_timeout (sticky), ctrl_state (debug)
// Optional: YSYX_041461_STALL_CNT_EN adds 64-bit stall/load-use counters.
module ysyx_041461_pipe_ctrl
  import ysyx_041461_pipe_ctrl_pkg::*;
#(
  parameter int LSU_TIMEOUT = ysyx_041461_PCTRL_LSU_TIMEOUT,
  parameter int TO_W        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       exe_valid,
  input  logic [4:0] exe_rd,
  input  logic       exe_is_load,
  input  logic       exe_is_mdu,
  input  logic       exe_branch_taken,
  input  logic       mdu_done,
  input  logic       mem_valid,
  input  logic       mem_access,
  input  logic       lsu_ack,
  input  logic       wb_trap,
  output logic       pc_enable,
  output logic       IDreg_enable,
  output logic       EXEreg_enable,
  output logic       MEMreg_enable,
  output logic       WBreg_enable,
  output logic       IDreg_valid_fromCD,
  output logic       EXEreg_valid_fromCD,
  output logic       MEMreg_valid_fromCD,
  output logic       WBreg_valid_fromCD,
  output logic       mdu_start,
  output logic       mdu_kill,
  output logic       lsu_req,
  output logic       lsu_timeout,
  output logic [1:0] ctrl_state
`ifdef YSYX_041461_STALL_CNT_EN
  ,
  output logic [63:0] stall_lsu_cnt,
  output logic [63:0] stall_mdu_cnt,
  output logic [63:0] load_use_cnt
`endif
);

  pctrl_state_e state, state_nxt;
  pctrl_en_t    en;
  pctrl_vld_t   vld;
  logic         load_use, lu_bubble;
  logic         start_c, kill_c, req_c;
  logic [TO_W-1:0] wd, wd_inc;

  ysyx_041461_hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .exe_valid   (exe_valid),
    .exe_rd      (exe_rd),
    .exe_is_load (exe_is_load),
    .load_use    (load_use)
  );

  always_comb begin
    state_nxt = state;
    en        = '1;
    vld       = '1;
    start_c   = 1'b0;
    kill_c    = 1'b0;
    req_c     = 1'b0;
    lu_bubble = 1'b0;
    unique case (state)
      ysyx_041461_PCTRL_RUN: begin
        if (wb_trap) begin
          vld = '0;
        end else if (mem_valid && mem_access) begin
          // Freeze everything up to MEM; WB drains and then sees bubbles.
          en        = '{pc: 1'b0, id: 1'b0, exe: 1'b0, mem: 1'b0, wb: 1'b1};
          vld.wb    = 1'b0;
          req_c     = 1'b1;
          state_nxt = ysyx_041461_PCTRL_LSU_WAIT;
        end else if (exe_valid && exe_is_mdu) begin
          en        = '{pc: 1'b0, id: 1'b0, exe: 1'b0, mem: 1'b1, wb: 1'b1};
          vld.mem   = 1'b0;
          start_c   = 1'b1;
          state_nxt = ysyx_041461_PCTRL_MDU_WAIT;
        end else if (exe_valid && exe_branch_taken) begin
          vld.id  = 1'b0;
          vld.exe = 1'b0;
        end else if (load_use) begin
          // Single bubble: next cycle the load has left EXE and the hazard clears.
          en.pc     = 1'b0;
          en.id     = 1'b0;
          vld.exe   = 1'b0;
          lu_bubble = 1'b1;
        end
      end
      ysyx_041461_PCTRL_MDU_WAIT: begin
        if (wb_trap) begin
          vld       = '0;
          kill_c    = 1'b1;
          state_nxt = ysyx_041461_PCTRL_RUN;
        end else if (mdu_done) begin
          state_nxt = ysyx_041461_PCTRL_RUN;
        end else begin
          en      = '{pc: 1'b0, id: 1'b0, exe: 1'b0, mem: 1'b1, wb: 1'b1};
          vld.mem = 1'b0;
        end
      end
      ysyx_041461_PCTRL_LSU_WAIT: begin
        // wb_trap cannot occur here: WB only ever holds a bubble in this state.
        req_c = 1'b1;
        if (lsu_ack) begin
          if (exe_valid && exe_is_mdu) begin
            en        = '{pc: 1'b0, id: 1'b0, exe: 1'b0, mem: 1'b1, wb: 1'b1};
            vld.mem   = 1'b0;
            start_c   = 1'b1;
            state_nxt = ysyx_041461_PCTRL_MDU_WAIT;
          end else begin
            state_nxt = ysyx_041461_PCTRL_RUN;
          end
        end else begin
          en     = '{pc: 1'b0, id: 1'b0, exe: 1'b0, mem: 1'b0, wb: 1'b1};
          vld.wb = 1'b0;
        end
      end
      default: state_nxt = ysyx_041461_PCTRL_RUN;
    endcase
    // Reset overrides combinationally so strobes drop without waiting for a clock.
    if (rst) begin
      en        = '1;
      vld       = '0;
      start_c   = 1'b0;
      kill_c    = 1'b0;
      req_c     = 1'b0;
      lu_bubble = 1'b0;
    end
  end

  assign wd_inc = (wd == {TO_W{1'b1}}) ? wd : wd + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ysyx_041461_PCTRL_RUN;
      wd          <= '0;
      lsu_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ysyx_041461_PCTRL_LSU_WAIT && !lsu_ack) begin
        wd <= wd_inc;
        if (wd_inc == TO_W'(LSU_TIMEOUT)) lsu_timeout <= 1'b1;
      end else begin
        wd <= '0;
      end
    end
  end

`ifdef YSYX_041461_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_lsu_cnt <= '0;
      stall_mdu_cnt <= '0;
      load_use_cnt  <= '0;
    end else begin
      if (state == ysyx_041461_PCTRL_LSU_WAIT) stall_lsu_cnt <= stall_lsu_cnt + 64'd1;
      if (state == ysyx_041461_PCTRL_MDU_WAIT) stall_mdu_cnt <= stall_mdu_cnt + 64'd1;
      if (lu_bubble)                           load_use_cnt  <= load_use_cnt + 64'd1;
    end
  end
`endif

  assign pc_enable           = en.pc;
  assign IDreg_enable        = en.id;
  assign EXEreg_enable       = en.exe;
  assign MEMreg_enable       = en.mem;
  assign WBreg_enable        = en.wb;
  assign IDreg_valid_fromCD  = vld.id;
  assign EXEreg_valid_fromCD = vld.exe;
  assign MEMreg_valid_fromCD = vld.mem;
  assign WBreg_valid_fromCD  = vld.wb;
  assign mdu_start           = start_c;
  assign mdu_kill            = kill_c;
  assign lsu_req             = req_c;
  assign ctrl_state          = state;

endmodule
